// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory controller between the instruction-fetch
// port (F, read-only) and the data load/store port (D). Ties are broken
// round-robin. Each granted request is captured into a request register that
// drives the controller until it acks. A watchdog ends a transaction the
// controller never acks and reports it as an error on the owning port.
module mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              nrst,
  // fetch port
  input  logic              f_read_en,
  input  logic              f_dbl,
  input  logic [ADDR_W-1:0] f_addr,
  output logic [DATA_W-1:0] f_rdata,
  output logic              f_ack,
  output logic              f_err,
  // data port
  input  logic              d_read_en,
  input  logic              d_write_en,
  input  logic              d_dbl,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              d_err,
  // memory controller
  output logic              mc_read_en,
  output logic              mc_write_en,
  output logic              mc_dbl,
  output logic [ADDR_W-1:0] mc_addr,
  output logic [DATA_W-1:0] mc_wdata,
  input  logic [DATA_W-1:0] mc_rdata,
  input  logic              mc_ack
);

  typedef enum logic [1:0] {IDLE, GRANT_F, GRANT_D, RELEASE} state_t;

  // Abort happens in the cycle where count equals this value.
  localparam logic [7:0] COUNT_MAX = 8'(TIMEOUT - 1);

  state_t              state;
  logic                last_d;    // 1 when D won the most recent grant
  logic [7:0]          count;
  logic                req_write;
  logic                req_dbl;
  logic [ADDR_W-1:0]   req_addr;
  logic [DATA_W-1:0]   req_wdata;

  logic req_f;
  logic req_d;
  logic granted;
  logic timeout_hit;

  assign req_f       = f_read_en;
  assign req_d       = d_read_en | d_write_en;
  assign granted     = (state == GRANT_F) || (state == GRANT_D);
  assign timeout_hit = (count == COUNT_MAX);

  // Controller requests come only from the latched request while a grant is
  // active, so an async reset (state -> IDLE) drops them immediately.
  always_comb begin
    mc_read_en  = granted && !req_write;
    mc_write_en = granted &&  req_write;
    mc_dbl      = granted &&  req_dbl;
    mc_addr     = granted ? req_addr  : '0;
    mc_wdata    = granted ? req_wdata : '0;
  end

  // Arbitration FSM: grant, watchdog, response capture and ack/err pulses.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // branch reads the pre-edge values of state/count/last_d regardless of order.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= IDLE;
      last_d    <= 1'b1;
      count     <= '0;
      req_write <= 1'b0;
      req_dbl   <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      f_rdata   <= '0;
      f_ack     <= 1'b0;
      f_err     <= 1'b0;
      d_rdata   <= '0;
      d_ack     <= 1'b0;
      d_err     <= 1'b0;
    end else begin
      // ack/err are single-cycle pulses; only the grant exit raises them
      f_ack <= 1'b0;
      f_err <= 1'b0;
      d_ack <= 1'b0;
      d_err <= 1'b0;
      case (state)
        IDLE: begin
          if (req_f && (!req_d || last_d)) begin
            req_write <= 1'b0;
            req_dbl   <= f_dbl;
            req_addr  <= f_addr;
            req_wdata <= '0;
            last_d    <= 1'b0;
            count     <= '0;
            state     <= GRANT_F;
          end else if (req_d) begin
            // read takes priority when both strobes are high
            req_write <= !d_read_en;
            req_dbl   <= d_dbl;
            req_addr  <= d_addr;
            req_wdata <= d_wdata;
            last_d    <= 1'b1;
            count     <= '0;
            state     <= GRANT_D;
          end
        end
        GRANT_F, GRANT_D: begin
          if (mc_ack) begin
            if (state == GRANT_F) begin
              f_rdata <= mc_rdata;
              f_ack   <= 1'b1;
            end else begin
              if (!req_write) d_rdata <= mc_rdata;
              d_ack <= 1'b1;
            end
            state <= RELEASE;
          end else if (timeout_hit) begin
            if (state == GRANT_F) begin
              f_rdata <= '0;
              f_ack   <= 1'b1;
              f_err   <= 1'b1;
            end else begin
              d_rdata <= '0;
              d_ack   <= 1'b1;
              d_err   <= 1'b1;
            end
            state <= RELEASE;
          end else begin
            count <= count + 8'd1;
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter. A short TIMEOUT keeps the watchdog
// scenarios quick. Inputs are driven and outputs sampled on the falling edge.
module tb_mem_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          nrst;
  logic          f_read_en, f_dbl;
  logic [AW-1:0] f_addr;
  logic [DW-1:0] f_rdata;
  logic          f_ack, f_err;
  logic          d_read_en, d_write_en, d_dbl;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          d_ack, d_err;
  logic          mc_read_en, mc_write_en, mc_dbl;
  logic [AW-1:0] mc_addr;
  logic [DW-1:0] mc_wdata, mc_rdata;
  logic          mc_ack;

  int errors = 0;
  int checks = 0;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .nrst(nrst),
    .f_read_en(f_read_en), .f_dbl(f_dbl), .f_addr(f_addr),
    .f_rdata(f_rdata), .f_ack(f_ack), .f_err(f_err),
    .d_read_en(d_read_en), .d_write_en(d_write_en), .d_dbl(d_dbl),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
    .d_ack(d_ack), .d_err(d_err),
    .mc_read_en(mc_read_en), .mc_write_en(mc_write_en), .mc_dbl(mc_dbl),
    .mc_addr(mc_addr), .mc_wdata(mc_wdata), .mc_rdata(mc_rdata),
    .mc_ack(mc_ack)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    f_read_en = 0; f_dbl = 0; f_addr = '0;
    d_read_en = 0; d_write_en = 0; d_dbl = 0; d_addr = '0; d_wdata = '0;
    mc_rdata = '0; mc_ack = 0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    nrst = 0;
    repeat (2) @(negedge clk);
    nrst = 1;
    @(negedge clk);
  endtask

  // Waits (bounded) for the controller request; n = falling edges waited.
  task automatic wait_grant(output int n);
    n = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (mc_read_en || mc_write_en) begin
        n = i;
        break;
      end
    end
    checks++;
    if (n < 0) begin
      errors++;
      $display("FAIL wait_grant: no mc request within 20 cycles");
    end
  endtask

  // One-cycle controller ack; returns at the RELEASE sampling point.
  task automatic mc_respond(input logic [DW-1:0] data);
    mc_ack = 1; mc_rdata = data;
    @(negedge clk);
    mc_ack = 0; mc_rdata = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    nrst = 0;
    @(negedge clk);
    checks++;
    if ({f_ack, f_err, d_ack, d_err, mc_read_en, mc_write_en, mc_dbl} !== 7'b0 ||
        f_rdata !== 16'h0 || d_rdata !== 16'h0 || mc_addr !== 16'h0 || mc_wdata !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs: f_ack=%b d_ack=%b mc_rd=%b mc_wr=%b f_rdata=%h d_rdata=%h mc_addr=%h exp all 0",
               f_ack, d_ack, mc_read_en, mc_write_en, f_rdata, d_rdata, mc_addr);
    end
    nrst = 1;
    @(negedge clk);
  endtask

  task automatic test_f_read();
    int n;
    apply_reset();
    f_read_en = 1; f_dbl = 1; f_addr = 16'h8000;
    wait_grant(n);
    checks++;
    if (n !== 1) begin errors++; $display("FAIL f_latency: got %0d exp 1", n); end
    checks++;
    if (mc_read_en !== 1 || mc_write_en !== 0 || mc_dbl !== 1 || mc_addr !== 16'h8000) begin
      errors++;
      $display("FAIL f_mc_req: rd=%b wr=%b dbl=%b addr=%h exp 1 0 1 8000", mc_read_en, mc_write_en, mc_dbl, mc_addr);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (f_ack !== 0) begin errors++; $display("FAIL f_early_ack: got %b exp 0", f_ack); end
    mc_respond(16'hBEEF);
    checks++;
    if (f_ack !== 1 || f_err !== 0 || f_rdata !== 16'hBEEF || mc_read_en !== 0) begin
      errors++;
      $display("FAIL f_done: ack=%b err=%b rdata=%h mc_rd=%b exp 1 0 beef 0", f_ack, f_err, f_rdata, mc_read_en);
    end
    f_read_en = 0;
    @(negedge clk);
    checks++;
    if (f_ack !== 0 || f_rdata !== 16'hBEEF) begin
      errors++;
      $display("FAIL f_pulse: ack=%b rdata=%h exp 0 beef", f_ack, f_rdata);
    end
  endtask

  task automatic test_round_robin();
    int n;
    logic exp_f;
    apply_reset();
    f_read_en = 1; f_addr = 16'h0100;
    d_read_en = 1; d_addr = 16'h0200;
    for (int i = 0; i < 4; i++) begin
      exp_f = (i % 2 == 0);
      wait_grant(n);
      checks++;
      if (mc_addr !== (exp_f ? 16'h0100 : 16'h0200)) begin
        errors++;
        $display("FAIL rr_grant%0d: mc_addr=%h exp %h", i, mc_addr, exp_f ? 16'h0100 : 16'h0200);
      end
      mc_respond(16'hA000 + 16'(i));
      checks++;
      if (f_ack !== exp_f || d_ack !== !exp_f) begin
        errors++;
        $display("FAIL rr_ack%0d: f_ack=%b d_ack=%b exp %b %b", i, f_ack, d_ack, exp_f, !exp_f);
      end
    end
    checks++;
    if (f_rdata !== 16'hA002 || d_rdata !== 16'hA003) begin
      errors++;
      $display("FAIL rr_data: f_rdata=%h d_rdata=%h exp a002 a003", f_rdata, d_rdata);
    end
    f_read_en = 0; d_read_en = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_d_write_hold();
    int n;
    apply_reset();
    d_write_en = 1; d_dbl = 1; d_addr = 16'h9000; d_wdata = 16'h1234;
    wait_grant(n);
    checks++;
    if (mc_write_en !== 1 || mc_read_en !== 0 || mc_dbl !== 1) begin
      errors++;
      $display("FAIL w_req: wr=%b rd=%b dbl=%b exp 1 0 1", mc_write_en, mc_read_en, mc_dbl);
    end
    d_addr = 16'hAAAA; d_wdata = 16'h5555;
    repeat (2) @(negedge clk);
    checks++;
    if (mc_addr !== 16'h9000 || mc_wdata !== 16'h1234) begin
      errors++;
      $display("FAIL w_hold: addr=%h wdata=%h exp 9000 1234", mc_addr, mc_wdata);
    end
    mc_respond(16'hDEAD);
    checks++;
    if (d_ack !== 1 || d_err !== 0 || d_rdata !== 16'h0 || mc_write_en !== 0) begin
      errors++;
      $display("FAIL w_done: ack=%b err=%b rdata=%h mc_wr=%b exp 1 0 0000 0", d_ack, d_err, d_rdata, mc_write_en);
    end
    d_write_en = 0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int n;
    apply_reset();
    d_read_en = 1; d_addr = 16'h3000;
    wait_grant(n);
    mc_respond(16'h7777);
    d_read_en = 0;
    checks++;
    if (d_rdata !== 16'h7777) begin errors++; $display("FAIL to_pre_read: got %h exp 7777", d_rdata); end
    @(negedge clk);
    d_write_en = 1; d_addr = 16'h1000; d_wdata = 16'h00FF;
    wait_grant(n);
    f_read_en = 1; f_addr = 16'h0400;
    n = 0;
    while (d_ack !== 1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== TO) begin errors++; $display("FAIL to_cycles: got %0d exp %0d", n, TO); end
    checks++;
    if (d_ack !== 1 || d_err !== 1 || d_rdata !== 16'h0 || f_ack !== 0) begin
      errors++;
      $display("FAIL to_abort: ack=%b err=%b rdata=%h f_ack=%b exp 1 1 0000 0", d_ack, d_err, d_rdata, f_ack);
    end
    d_write_en = 0;
    wait_grant(n);
    checks++;
    if (mc_addr !== 16'h0400 || mc_read_en !== 1) begin
      errors++;
      $display("FAIL to_next_f: addr=%h rd=%b exp 0400 1", mc_addr, mc_read_en);
    end
    mc_respond(16'h0F0F);
    checks++;
    if (f_ack !== 1 || f_err !== 0 || f_rdata !== 16'h0F0F || d_ack !== 0) begin
      errors++;
      $display("FAIL to_f_done: ack=%b err=%b rdata=%h d_ack=%b exp 1 0 0f0f 0", f_ack, f_err, f_rdata, d_ack);
    end
    f_read_en = 0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_grant();
    int n;
    apply_reset();
    d_read_en = 1; d_addr = 16'h6000;
    wait_grant(n);
    #2 nrst = 0;
    #1;
    checks++;
    if (mc_read_en !== 0 || mc_write_en !== 0 || mc_addr !== 16'h0) begin
      errors++;
      $display("FAIL rst_drop: rd=%b wr=%b addr=%h exp 0 0 0000", mc_read_en, mc_write_en, mc_addr);
    end
    d_read_en = 0;
    @(negedge clk);
    checks++;
    if (d_ack !== 0 || d_err !== 0) begin errors++; $display("FAIL rst_no_ack: ack=%b err=%b exp 0 0", d_ack, d_err); end
    nrst = 1;
    @(negedge clk);
    checks++;
    if (d_ack !== 0 || mc_read_en !== 0) begin errors++; $display("FAIL rst_idle: d_ack=%b mc_rd=%b exp 0 0", d_ack, mc_read_en); end
    f_read_en = 1; f_addr = 16'h0500;
    wait_grant(n);
    checks++;
    if (mc_addr !== 16'h0500) begin errors++; $display("FAIL rst_f_addr: got %h exp 0500", mc_addr); end
    mc_respond(16'h5A5A);
    checks++;
    if (f_ack !== 1 || f_err !== 0 || f_rdata !== 16'h5A5A) begin
      errors++;
      $display("FAIL rst_f_done: ack=%b err=%b rdata=%h exp 1 0 5a5a", f_ack, f_err, f_rdata);
    end
    f_read_en = 0;
    @(negedge clk);
  endtask

  task automatic test_ack_on_timeout();
    int n;
    apply_reset();
    d_read_en = 1; d_write_en = 1; d_addr = 16'h2000; d_wdata = 16'h9999;
    wait_grant(n);
    checks++;
    if (mc_read_en !== 1 || mc_write_en !== 0) begin
      errors++;
      $display("FAIL rw_read_first: rd=%b wr=%b exp 1 0", mc_read_en, mc_write_en);
    end
    repeat (TO - 1) @(negedge clk);
    checks++;
    if (d_ack !== 0 || mc_read_en !== 1) begin
      errors++;
      $display("FAIL edge_before: d_ack=%b mc_rd=%b exp 0 1", d_ack, mc_read_en);
    end
    mc_respond(16'h4242);
    checks++;
    if (d_ack !== 1 || d_err !== 0 || d_rdata !== 16'h4242) begin
      errors++;
      $display("FAIL edge_ack: ack=%b err=%b rdata=%h exp 1 0 4242", d_ack, d_err, d_rdata);
    end
    d_read_en = 0; d_write_en = 0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_f_read();
    test_round_robin();
    test_d_write_hold();
    test_timeout();
    test_reset_mid_grant();
    test_ack_on_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
